// File: rtl/float_to_int_pkg.sv
// -----------------------------------------------------------------------------
// float_to_int_pkg
// Shared definitions for the pipelined float -> integer converter:
//   RM_*        rounding-mode encodings carried on in_rmode
//   fti_cls_e   operand class decided in the classify stage
//   fti_*()     elaboration-time helpers for the exponent bias and grid widths
// -----------------------------------------------------------------------------
package float_to_int_pkg;

   localparam logic [1:0] RM_RZ  = 2'b00;   // toward zero
   localparam logic [1:0] RM_RNE = 2'b01;   // nearest, ties to even
   localparam logic [1:0] RM_RUP = 2'b10;   // toward +infinity
   localparam logic [1:0] RM_RDN = 2'b11;   // toward -infinity

   typedef enum logic [2:0] {
      CLS_ZERO   = 3'd0,
      CLS_DENORM = 3'd1,
      CLS_NORM   = 3'd2,
      CLS_INF    = 3'd3,
      CLS_NAN    = 3'd4
   } fti_cls_e;

   // Exponent bias for an exponent field of exp_w bits.
   function automatic int fti_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Alignment grid: int_w integer bits, one guard bit, and frac_w bits
   // below guard so that an exponent of -1 still keeps every significand bit.
   function automatic int fti_grid_w(input int int_w, input int frac_w);
      return int_w + frac_w + 1;
   endfunction

   // Width of a shift amount covering 0 .. int_w.
   function automatic int fti_shamt_w(input int int_w);
      return $clog2(int_w + 1);
   endfunction

endpackage

// File: rtl/fti_round.sv
// -----------------------------------------------------------------------------
// fti_round
// Combinational round / sign / saturate unit (third pipeline stage logic).
// Inputs : sign, rmode, cls       - operand sign, rounding mode, class
//          mag, guard, sticky     - aligned integer magnitude and lost bits
//          pre_ovf                - exponent already too large for INT_W
// Outputs: data                   - two's-complement result (saturated code
//                                   2^(INT_W-1) when invalid)
//          invalid, inexact, denorm
// -----------------------------------------------------------------------------
module fti_round
   import float_to_int_pkg::*;
#(
   parameter int INT_W = 32
) (
   input  logic             sign,
   input  logic [1:0]       rmode,
   input  fti_cls_e         cls,
   input  logic [INT_W-1:0] mag,
   input  logic             guard,
   input  logic             sticky,
   input  logic             pre_ovf,
   output logic [INT_W-1:0] data,
   output logic             invalid,
   output logic             inexact,
   output logic             denorm
);

   logic           lost;
   logic           inc;
   logic [INT_W:0] rmag;
   logic           ovf;

   always_comb begin
      lost = guard | sticky;

      case (rmode)
         RM_RZ:   inc = 1'b0;
         RM_RNE:  inc = guard & (sticky | mag[0]);
         RM_RUP:  inc = ~sign & lost;
         default: inc = sign & lost;
      endcase

      // One extra bit so a carry out of the top magnitude bit is visible.
      rmag = {1'b0, mag} + (INT_W+1)'(inc);

      // Negative side may reach exactly 2^(INT_W-1); positive side may not.
      if (sign) begin
         ovf = rmag[INT_W] | (rmag[INT_W-1] & (|rmag[INT_W-2:0]));
      end else begin
         ovf = rmag[INT_W] | rmag[INT_W-1];
      end

      invalid = (cls == CLS_NAN) | (cls == CLS_INF) | pre_ovf | ovf;

      if (invalid) begin
         data    = {1'b1, {(INT_W-1){1'b0}}};
         inexact = 1'b0;
      end else begin
         data    = sign ? -rmag[INT_W-1:0] : rmag[INT_W-1:0];
         inexact = lost;
      end

      denorm = (cls == CLS_DENORM);
   end

endmodule

// File: rtl/float_to_int_pipe.sv
// -----------------------------------------------------------------------------
// float_to_int_pipe
// Three-stage pipelined IEEE-754-style float to signed integer converter with
// valid/ready handshakes on both sides.
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         input handshake
//   in_data  {sign,exp,frac}    operand, in_rmode rounding mode (travels along)
//   out_valid / out_ready       output handshake
//   out_data                    converted integer
//   out_invalid                 NaN, infinity or out of range
//   out_inexact                 nonzero bits discarded by rounding
//   out_denorm                  operand was subnormal
// Stages: S1 classify -> S2 align -> S3 round (fti_round) -> output registers.
// -----------------------------------------------------------------------------
module float_to_int_pipe
   import float_to_int_pkg::*;
#(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23,
   parameter int INT_W  = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [EXP_W+FRAC_W:0]   in_data,
   input  logic [1:0]              in_rmode,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [INT_W-1:0]        out_data,
   output logic                    out_invalid,
   output logic                    out_inexact,
   output logic                    out_denorm
);

   localparam int BIAS   = fti_bias(EXP_W);
   localparam int SIG_W  = FRAC_W + 1;
   localparam int GRID_W = fti_grid_w(INT_W, FRAC_W);
   localparam int SH_W   = fti_shamt_w(INT_W);

   // ---------------- handshake / stage valids ----------------
   logic v1_q, v2_q, v3_q;
   logic v1_d, v2_d, v3_d;
   logic ld1, ld2, ld3;

   // ---------------- S1 classify ----------------
   logic                    in_sign;
   logic [EXP_W-1:0]        in_exp;
   logic [FRAC_W-1:0]       in_frac;
   fti_cls_e                c_cls;
   logic [SIG_W-1:0]        c_sig;
   logic signed [EXP_W:0]   c_exp;

   logic                    s1_sign_q,  s1_sign_d;
   logic [1:0]              s1_rmode_q, s1_rmode_d;
   fti_cls_e                s1_cls_q,   s1_cls_d;
   logic [SIG_W-1:0]        s1_sig_q,   s1_sig_d;
   logic signed [EXP_W:0]   s1_exp_q,   s1_exp_d;

   // ---------------- S2 align ----------------
   int                      exp_i;
   logic [GRID_W-1:0]       grid;
   logic [INT_W-1:0]        a_mag;
   logic                    a_guard, a_sticky, a_pre_ovf;

   logic                    s2_sign_q,    s2_sign_d;
   logic [1:0]              s2_rmode_q,   s2_rmode_d;
   fti_cls_e                s2_cls_q,     s2_cls_d;
   logic [INT_W-1:0]        s2_mag_q,     s2_mag_d;
   logic                    s2_guard_q,   s2_guard_d;
   logic                    s2_sticky_q,  s2_sticky_d;
   logic                    s2_pre_ovf_q, s2_pre_ovf_d;

   // ---------------- S3 round / output ----------------
   logic [INT_W-1:0]        r_data;
   logic                    r_invalid, r_inexact, r_denorm;

   logic [INT_W-1:0]        out_data_q,    out_data_d;
   logic                    out_invalid_q, out_invalid_d;
   logic                    out_inexact_q, out_inexact_d;
   logic                    out_denorm_q,  out_denorm_d;

   // A stage advances when it is empty or its successor advances, so a free
   // output slot ripples back to in_ready within the same cycle.
   always_comb begin
      ld3  = ~v3_q | out_ready;
      ld2  = ~v2_q | ld3;
      ld1  = ~v1_q | ld2;
      v1_d = ld1 ? in_valid : v1_q;
      v2_d = ld2 ? v1_q     : v2_q;
      v3_d = ld3 ? v2_q     : v3_q;
   end

   assign in_ready  = ld1;
   assign out_valid = v3_q;

   // S1: split fields, decide class, attach hidden bit.
   always_comb begin
      in_sign = in_data[EXP_W+FRAC_W];
      in_exp  = in_data[FRAC_W +: EXP_W];
      in_frac = in_data[FRAC_W-1:0];

      c_cls = CLS_NORM;
      c_sig = {1'b1, in_frac};
      c_exp = (EXP_W+1)'(int'(in_exp) - BIAS);

      if (in_exp == '0) begin
         // Subnormals use the minimum normal exponent with no hidden bit.
         c_sig = {1'b0, in_frac};
         c_exp = (EXP_W+1)'(1 - BIAS);
         c_cls = (in_frac == '0) ? CLS_ZERO : CLS_DENORM;
      end else if (&in_exp) begin
         c_cls = (in_frac == '0) ? CLS_INF : CLS_NAN;
      end

      s1_sign_d  = ld1 ? in_sign  : s1_sign_q;
      s1_rmode_d = ld1 ? in_rmode : s1_rmode_q;
      s1_cls_d   = ld1 ? c_cls    : s1_cls_q;
      s1_sig_d   = ld1 ? c_sig    : s1_sig_q;
      s1_exp_d   = ld1 ? c_exp    : s1_exp_q;
   end

   // S2: the grid value is sig * 2^(exp+1), i.e. binary point sits just above
   // the guard bit. Exponents -1 .. INT_W-1 fit without losing any bit.
   always_comb begin
      exp_i     = int'(s1_exp_q);
      grid      = '0;
      a_mag     = '0;
      a_guard   = 1'b0;
      a_sticky  = 1'b0;
      a_pre_ovf = 1'b0;

      if (exp_i >= INT_W) begin
         a_pre_ovf = 1'b1;
      end else if (exp_i < -1) begin
         // Value is below one half: everything lands in sticky.
         a_sticky = |s1_sig_q;
      end else begin
         grid     = GRID_W'(s1_sig_q) << SH_W'(exp_i + 1);
         a_mag    = grid[GRID_W-1 -: INT_W];
         a_guard  = grid[FRAC_W];
         a_sticky = |grid[FRAC_W-1:0];
      end

      s2_sign_d    = ld2 ? s1_sign_q  : s2_sign_q;
      s2_rmode_d   = ld2 ? s1_rmode_q : s2_rmode_q;
      s2_cls_d     = ld2 ? s1_cls_q   : s2_cls_q;
      s2_mag_d     = ld2 ? a_mag      : s2_mag_q;
      s2_guard_d   = ld2 ? a_guard    : s2_guard_q;
      s2_sticky_d  = ld2 ? a_sticky   : s2_sticky_q;
      s2_pre_ovf_d = ld2 ? a_pre_ovf  : s2_pre_ovf_q;
   end

   fti_round #(
      .INT_W (INT_W)
   ) u_round (
      .sign    (s2_sign_q),
      .rmode   (s2_rmode_q),
      .cls     (s2_cls_q),
      .mag     (s2_mag_q),
      .guard   (s2_guard_q),
      .sticky  (s2_sticky_q),
      .pre_ovf (s2_pre_ovf_q),
      .data    (r_data),
      .invalid (r_invalid),
      .inexact (r_inexact),
      .denorm  (r_denorm)
   );

   // Output registers only move on ld3, so a stalled result stays put.
   always_comb begin
      out_data_d    = ld3 ? r_data    : out_data_q;
      out_invalid_d = ld3 ? r_invalid : out_invalid_q;
      out_inexact_d = ld3 ? r_inexact : out_inexact_q;
      out_denorm_d  = ld3 ? r_denorm  : out_denorm_q;
   end

   assign out_data    = out_data_q;
   assign out_invalid = out_invalid_q;
   assign out_inexact = out_inexact_q;
   assign out_denorm  = out_denorm_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q          <= 1'b0;
         v2_q          <= 1'b0;
         v3_q          <= 1'b0;
         s1_sign_q     <= 1'b0;
         s1_rmode_q    <= RM_RZ;
         s1_cls_q      <= CLS_ZERO;
         s1_sig_q      <= '0;
         s1_exp_q      <= '0;
         s2_sign_q     <= 1'b0;
         s2_rmode_q    <= RM_RZ;
         s2_cls_q      <= CLS_ZERO;
         s2_mag_q      <= '0;
         s2_guard_q    <= 1'b0;
         s2_sticky_q   <= 1'b0;
         s2_pre_ovf_q  <= 1'b0;
         out_data_q    <= '0;
         out_invalid_q <= 1'b0;
         out_inexact_q <= 1'b0;
         out_denorm_q  <= 1'b0;
      end else begin
         v1_q          <= v1_d;
         v2_q          <= v2_d;
         v3_q          <= v3_d;
         s1_sign_q     <= s1_sign_d;
         s1_rmode_q    <= s1_rmode_d;
         s1_cls_q      <= s1_cls_d;
         s1_sig_q      <= s1_sig_d;
         s1_exp_q      <= s1_exp_d;
         s2_sign_q     <= s2_sign_d;
         s2_rmode_q    <= s2_rmode_d;
         s2_cls_q      <= s2_cls_d;
         s2_mag_q      <= s2_mag_d;
         s2_guard_q    <= s2_guard_d;
         s2_sticky_q   <= s2_sticky_d;
         s2_pre_ovf_q  <= s2_pre_ovf_d;
         out_data_q    <= out_data_d;
         out_invalid_q <= out_invalid_d;
         out_inexact_q <= out_inexact_d;
         out_denorm_q  <= out_denorm_d;
      end
   end

endmodule

// File: tb/tb_float_to_int_pipe.sv
// -----------------------------------------------------------------------------
// tb_float_to_int_pipe
// Directed vector table, a backpressure/reset sequence, and a randomized
// stream checked against a real-arithmetic reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_float_to_int_pipe;

   localparam int NVEC = 19;
   localparam int NRND = 100;
   localparam int HMAX = 8192;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [1:0]  in_rmode = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_invalid, out_inexact, out_denorm;

   always #5 clk = ~clk;

   float_to_int_pipe #(
      .EXP_W  (8),
      .FRAC_W (23),
      .INT_W  (32)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_rmode    (in_rmode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_invalid (out_invalid),
      .out_inexact (out_inexact),
      .out_denorm  (out_denorm)
   );

   typedef struct {
      logic [31:0] w;
      logic [1:0]  rm;
      logic [31:0] d;
      logic        inv;
      logic        inex;
      logic        den;
   } vec_t;

   typedef struct {
      logic [31:0] w;
      logic [31:0] d;
      logic        inv;
      logic        inex;
      logic        den;
      int          acc;
   } exp_t;

   vec_t vecs [NVEC];
   exp_t sb [$];
   bit   ready_hist [HMAX];

   int n_cmp = 0;
   int n_bad = 0;
   int edge_cnt = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Reference: exact value as a real, rounded with floor/ceil, range-checked.
   function automatic void ref_model(input logic [31:0] w, input logic [1:0] rm,
                                     output logic [31:0] d, output logic inv,
                                     output logic inex, output logic den);
      int     e, f;
      real    v, fl, r;
      longint ri;
      e    = int'(w[30:23]);
      f    = int'(w[22:0]);
      den  = (e == 0) && (f != 0);
      d    = 32'h8000_0000;
      inv  = 1'b1;
      inex = 1'b0;
      if (e == 255) return;
      if (e == 0) v = real'(f) * (2.0 ** (-149.0));
      else        v = real'(f + 8388608) * (2.0 ** real'(e - 150));
      if (w[31]) v = -v;
      case (rm)
         2'b00: r = (v < 0.0) ? $ceil(v) : $floor(v);
         2'b01: begin
            fl = $floor(v);
            if (v - fl > 0.5)      r = fl + 1.0;
            else if (v - fl < 0.5) r = fl;
            else                   r = ($floor(fl / 2.0) * 2.0 == fl) ? fl : fl + 1.0;
         end
         2'b10: r = $ceil(v);
         default: r = $floor(v);
      endcase
      if (r > 2147483647.0 || r < -2147483648.0) return;
      ri   = longint'(r);
      d    = ri[31:0];
      inv  = 1'b0;
      inex = (r != v);
   endfunction

   function automatic logic [31:0] rand_word();
      logic [7:0]  e;
      logic [31:0] w;
      int          c;
      c = $urandom_range(0, 9);
      if (c == 0)      e = 8'h00;
      else if (c == 1) e = 8'hFF;
      else             e = 8'($urandom_range(110, 160));
      w = {1'($urandom), e, 23'($urandom)};
      if ($urandom_range(0, 7) == 0) w[22:0] = '0;
      return w;
   endfunction

   task automatic run_vec(input int i);
      int acc, lat;
      bit got;
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = vecs[i].w;
      in_rmode  = vecs[i].rm;
      acc = 0;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            acc = edge_cnt + 1;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (!got) begin
         chk($sformatf("vec%0d accept", i), 32'(in_ready), 32'd1);
         return;
      end
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (out_valid) got = 1'b1;
      end
      if (!got) begin
         chk($sformatf("vec%0d out_valid timeout", i), 32'(out_valid), 32'd1);
         return;
      end
      lat = edge_cnt + 1 - acc;
      chk($sformatf("vec%0d w=%h rm=%0d data", i, vecs[i].w, vecs[i].rm), out_data, vecs[i].d);
      chk($sformatf("vec%0d invalid", i), 32'(out_invalid), 32'(vecs[i].inv));
      chk($sformatf("vec%0d inexact", i), 32'(out_inexact), 32'(vecs[i].inex));
      chk($sformatf("vec%0d denorm", i), 32'(out_denorm), 32'(vecs[i].den));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
      $display("vec%0d w=%h rm=%0d -> %h inv=%0d inex=%0d den=%0d", i, vecs[i].w,
               vecs[i].rm, out_data, out_invalid, out_inexact, out_denorm);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] ws [3];
      logic [1:0]  rms [3];
      int          cnt, sent, rcv, cyc, lat, idx;
      bit          took;
      exp_t        e;
      logic [31:0] md;
      logic        minv, minex, mden;

      //          word           rm     data           inv   inex  den
      vecs[0]  = '{32'h3FC00000, 2'b01, 32'h00000002, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{32'h3FC00000, 2'b00, 32'h00000001, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{32'h3FC00000, 2'b11, 32'h00000001, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{32'h3FC00000, 2'b10, 32'h00000002, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{32'h40200000, 2'b01, 32'h00000002, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{32'hC0200000, 2'b01, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{32'hC0200000, 2'b11, 32'hFFFFFFFD, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{32'hCF000000, 2'b00, 32'h80000000, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{32'h4F000000, 2'b00, 32'h80000000, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{32'h7FC00000, 2'b01, 32'h80000000, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{32'hFF800000, 2'b00, 32'h80000000, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{32'h00000001, 2'b10, 32'h00000001, 1'b0, 1'b1, 1'b1};
      vecs[12] = '{32'h00000001, 2'b00, 32'h00000000, 1'b0, 1'b1, 1'b1};
      vecs[13] = '{32'h80000000, 2'b01, 32'h00000000, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{32'h4EFFFFFF, 2'b00, 32'h7FFFFF80, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{32'h3F000000, 2'b01, 32'h00000000, 1'b0, 1'b1, 1'b0};
      vecs[16] = '{32'h3F000000, 2'b10, 32'h00000001, 1'b0, 1'b1, 1'b0};
      vecs[17] = '{32'hBF800000, 2'b00, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      vecs[18] = '{32'hCF000001, 2'b00, 32'h80000000, 1'b1, 1'b0, 1'b0};

      // ---------------- reset ----------------
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #2 rst_n = 1'b1;
      @(negedge clk);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_data", out_data, 32'd0);
      chk("reset flags", {29'd0, out_invalid, out_inexact, out_denorm}, 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);

      // ---------------- directed table ----------------
      for (int i = 0; i < NVEC; i++) run_vec(i);

      // ---------------- fill under backpressure, then reset mid-flight ----------------
      ws[0] = 32'h00000001; rms[0] = 2'b10;
      ws[1] = 32'h3FC00000; rms[1] = 2'b01;
      ws[2] = 32'hC0200000; rms[2] = 2'b11;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data  = ws[k];
         in_rmode = rms[k];
         @(negedge clk);
         chk($sformatf("fill%0d in_ready", k), 32'(in_ready), 32'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("full in_ready", 32'(in_ready), 32'd0);
      chk("full out_valid", 32'(out_valid), 32'd1);
      chk("full out_data", out_data, 32'd1);
      chk("full inexact", 32'(out_inexact), 32'd1);
      chk("full denorm", 32'(out_denorm), 32'd1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk($sformatf("stall%0d out_data", k), out_data, 32'd1);
         chk($sformatf("stall%0d out_valid", k), 32'(out_valid), 32'd1);
      end
      #2 rst_n = 1'b0;
      #1;
      chk("async rst out_valid", 32'(out_valid), 32'd0);
      chk("async rst out_data", out_data, 32'd0);
      chk("async rst flags", {29'd0, out_invalid, out_inexact, out_denorm}, 32'd0);
      @(negedge clk); #2 rst_n = 1'b1;
      @(negedge clk);
      chk("post rst in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("post rst stale words", 32'(cnt), 32'd0);
      $display("reset-in-flight sequence done, stale words seen=%0d", cnt);

      // ---------------- random stream ----------------
      sent = 0; rcv = 0; cyc = 0;
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = 1'b1;
      in_data   = rand_word();
      in_rmode  = 2'($urandom);
      while (rcv < NRND && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         idx = edge_cnt + 1;
         if (idx < HMAX) ready_hist[idx] = out_ready;
         took = in_valid && in_ready;
         if (took) begin
            ref_model(in_data, in_rmode, md, minv, minex, mden);
            e.w = in_data; e.d = md; e.inv = minv; e.inex = minex; e.den = mden;
            e.acc = idx;
            sb.push_back(e);
            sent++;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL stream spurious output: got %h, want no transfer", out_data);
            end else begin
               e = sb.pop_front();
               lat = idx - e.acc;
               chk($sformatf("rnd%0d w=%h data", rcv, e.w), out_data, e.d);
               chk($sformatf("rnd%0d invalid", rcv), 32'(out_invalid), 32'(e.inv));
               chk($sformatf("rnd%0d inexact", rcv), 32'(out_inexact), 32'(e.inex));
               chk($sformatf("rnd%0d denorm", rcv), 32'(out_denorm), 32'(e.den));
               n_cmp++;
               if (lat < 3) begin
                  n_bad++;
                  $display("FAIL rnd%0d latency: got %0d, want >= 3", rcv, lat);
               end
               if (e.acc + 3 < HMAX && ready_hist[e.acc+1] && ready_hist[e.acc+2]
                   && ready_hist[e.acc+3])
                  chk($sformatf("rnd%0d latency unstalled", rcv), 32'(lat), 32'd3);
               $display("rnd%0d w=%h -> %h inv=%0d inex=%0d den=%0d lat=%0d", rcv, e.w,
                        out_data, out_invalid, out_inexact, out_denorm, lat);
               rcv++;
            end
         end
         @(posedge clk); #1;
         out_ready = ($urandom_range(0, 3) != 0);
         if (took || !in_valid) begin
            if (sent < NRND && $urandom_range(0, 4) != 0) begin
               in_valid = 1'b1;
               in_data  = rand_word();
               in_rmode = 2'($urandom);
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      if (rcv < NRND) begin
         n_cmp++;
         n_bad++;
         $display("FAIL stream timeout: got %0d results, want %0d", rcv, NRND);
      end
      chk("stream leftover words", 32'(sb.size()), 32'd0);
      in_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
